// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode/funct encodings and the fetch-state enum.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[31:26];
    endfunction

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection for the fetch stage: JR > JAL/J > branch > PC+4.
module next_pc_logic
    import mips_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    input  logic        pcsrc_i,
    input  logic        jal_i,
    input  logic        jr_i,
    input  logic [31:0] sign_imm_i,
    input  logic [31:0] rd1_i,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] next_pc_o,
    output logic        misaligned_o
);

    logic [31:0] target_raw;

    assign pc_plus4_o = pc_i + 32'd4;

    always_comb begin
        target_raw = pc_plus4_o;
        if (jr_i) begin
            target_raw = rd1_i;
        end else if (jal_i || (opcode_of(instr_i) == OP_J)) begin
            target_raw = {pc_plus4_o[31:28], instr_i[25:0], 2'b00};
        end else if (pcsrc_i) begin
            target_raw = pc_plus4_o + (sign_imm_i << 2);
        end
    end

    // Only a register target can carry stray low bits; they are always dropped.
    assign misaligned_o = (target_raw[1:0] != 2'b00);
    assign next_pc_o    = {target_raw[31:2], 2'b00};

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: PC register, imem req/ack handshake and next-PC update on retire.
// Optional sticky misaligned-target flag enabled by defining IFU_ALIGN_CHECK_EN.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              retire,
    input  logic              PCSrc,
    input  logic              JAL,
    input  logic              JR,
    input  logic [31:0]       SignImm,
    input  logic [31:0]       RD1,
    output logic              instr_valid,
    output logic [31:0]       Instr,
    output logic [5:0]        Opcode,
    output logic [5:0]        Funct,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] PCPlus4,
    output logic              align_err
);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       instr_q;
    logic              req_q;
    logic              valid_q;
    logic [31:0]       next_pc_d;
    logic              misaligned;

    next_pc_logic u_next_pc (
        .pc_i        (pc_q),
        .instr_i     (instr_q),
        .pcsrc_i     (PCSrc),
        .jal_i       (JAL),
        .jr_i        (JR),
        .sign_imm_i  (SignImm),
        .rd1_i       (RD1),
        .pc_plus4_o  (PCPlus4),
        .next_pc_o   (next_pc_d),
        .misaligned_o(misaligned)
    );

    // Reset abandons any outstanding request; an ack arriving afterwards lands in IDLE and is ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        instr_q <= imem_rdata;
                        state_q <= HOLD;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (retire) begin
                        pc_q    <= next_pc_d;
                        state_q <= FETCH;
                        req_q   <= 1'b1;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign Instr       = instr_q;
    assign Opcode      = instr_q[31:26];
    assign Funct       = instr_q[5:0];
    assign PC          = pc_q;

`ifdef IFU_ALIGN_CHECK_EN
    logic align_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            align_err_q <= 1'b0;
        end else if ((state_q == HOLD) && retire && misaligned) begin
            align_err_q <= 1'b1;
        end
    end

    assign align_err = align_err_q;
`else
    logic unused_misaligned;
    assign unused_misaligned = misaligned;
    assign align_err         = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (expects align_err set only with IFU_ALIGN_CHECK_EN).
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        retire;
    logic        PCSrc;
    logic        JAL;
    logic        JR;
    logic [31:0] SignImm;
    logic [31:0] RD1;
    logic        instr_valid;
    logic [31:0] Instr;
    logic [5:0]  Opcode;
    logic [5:0]  Funct;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        align_err;

    int tests = 0;
    int fails = 0;

`ifdef IFU_ALIGN_CHECK_EN
    localparam logic ALIGN_EXP = 1'b1;
`else
    localparam logic ALIGN_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .retire     (retire),
        .PCSrc      (PCSrc),
        .JAL        (JAL),
        .JR         (JR),
        .SignImm    (SignImm),
        .RD1        (RD1),
        .instr_valid(instr_valid),
        .Instr      (Instr),
        .Opcode     (Opcode),
        .Funct      (Funct),
        .PC         (PC),
        .PCPlus4    (PCPlus4),
        .align_err  (align_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] word);
        imem_ack   = 1'b1;
        imem_rdata = word;
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
    endtask

    task automatic do_retire(input logic pcsrc, input logic jal, input logic jr,
                             input logic [31:0] simm, input logic [31:0] rd1);
        PCSrc   = pcsrc;
        JAL     = jal;
        JR      = jr;
        SignImm = simm;
        RD1     = rd1;
        retire  = 1'b1;
        step();
        retire  = 1'b0;
        PCSrc   = 1'b0;
        JAL     = 1'b0;
        JR      = 1'b0;
        SignImm = 32'h0;
        RD1     = 32'h0;
    endtask

    task automatic plain_instr();
        do_fetch(32'h0000_0000);
        do_retire(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        reset      = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        retire     = 1'b0;
        PCSrc      = 1'b0;
        JAL        = 1'b0;
        JR         = 1'b0;
        SignImm    = 32'h0;
        RD1        = 32'h0;

        // Reset held, with a stray ack that must be ignored
        step();
        imem_ack = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        step();
        imem_ack = 1'b0;
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_pc", PC, 32'h0);
        chk("rst_instr", Instr, 32'h0);
        chk("rst_align", align_err, 1'b0);

        reset = 1'b0;
        chk("idle_req", imem_req, 1'b0);
        step();
        chk("fetch_req", imem_req, 1'b1);
        chk("fetch_addr0", imem_addr, 32'h0);

        // Ack arrives three cycles late
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wait_req", imem_req, 1'b1);
            chk("wait_valid", instr_valid, 1'b0);
        end
        do_fetch(32'h2002_0005);
        chk("hold_valid", instr_valid, 1'b1);
        chk("hold_instr", Instr, 32'h2002_0005);
        chk("hold_opcode", Opcode, 6'b001000);
        chk("hold_funct", Funct, 6'b000101);
        chk("hold_req", imem_req, 1'b0);

        // Stray ack during HOLD and no retire: everything stable
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        step();
        imem_ack = 1'b0;
        chk("hold_stable_instr", Instr, 32'h2002_0005);
        chk("hold_stable_valid", instr_valid, 1'b1);
        chk("hold_stable_pc", PC, 32'h0);

        do_retire(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("seq_addr4", imem_addr, 32'h4);
        chk("seq_req", imem_req, 1'b1);
        chk("seq_valid", instr_valid, 1'b0);

        // Walk to 0x10 then backward branch
        plain_instr();
        plain_instr();
        plain_instr();
        chk("pc_0x10", imem_addr, 32'h10);
        do_fetch(32'h1000_0000);
        chk("pcplus4_0x14", PCPlus4, 32'h14);
        do_retire(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0);
        chk("branch_back", imem_addr, 32'h4);

        plain_instr();
        plain_instr();
        plain_instr();
        do_fetch(32'h1000_0000);
        do_retire(1'b1, 1'b0, 1'b0, 32'h3, 32'h0);
        chk("branch_fwd", imem_addr, 32'h20);

        // JR to 0x40, then JAL, then J by opcode
        do_fetch(32'h0000_0008);
        do_retire(1'b0, 1'b0, 1'b1, 32'h0, 32'h40);
        chk("jr_0x40", imem_addr, 32'h40);
        do_fetch(32'h0C00_0100);
        chk("jal_opcode", Opcode, 6'b000011);
        chk("jal_pc", PC, 32'h40);
        chk("jal_pcplus4", PCPlus4, 32'h44);
        do_retire(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        chk("jal_target", imem_addr, 32'h400);
        do_fetch(32'h0800_0010);
        do_retire(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("j_opcode_target", imem_addr, 32'h40);

        // JR beats PCSrc
        do_fetch(32'h0000_0000);
        do_retire(1'b1, 1'b0, 1'b1, 32'h0000_0010, 32'h80);
        chk("jr_over_pcsrc", imem_addr, 32'h80);

        // PC wrap at the top of the address space
        do_fetch(32'h0000_0000);
        do_retire(1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFC);
        chk("top_addr", imem_addr, 32'hFFFF_FFFC);
        do_fetch(32'h0000_0000);
        chk("top_pcplus4", PCPlus4, 32'h0);
        do_retire(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("wrap_seq", imem_addr, 32'h0);
        do_fetch(32'h1000_0000);
        do_retire(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0);
        chk("wrap_branch", imem_addr, 32'hFFFF_FFFC);

        // Misaligned JR target: low bits cleared, flag depends on build
        do_fetch(32'h0000_0000);
        chk("pre_align", align_err, 1'b0);
        do_retire(1'b0, 1'b0, 1'b1, 32'h0, 32'h83);
        chk("misalign_addr", imem_addr, 32'h80);
        chk("misalign_flag", align_err, ALIGN_EXP);
        plain_instr();
        chk("after_misalign_addr", imem_addr, 32'h84);
        chk("align_sticky", align_err, ALIGN_EXP);

        // Async reset mid-FETCH with an ack in the same cycle
        imem_ack = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        reset = 1'b1;
        #1;
        chk("async_rst_req", imem_req, 1'b0);
        chk("async_rst_pc", PC, 32'h0);
        step();
        chk("rst_fetch_instr", Instr, 32'h0);
        chk("rst_fetch_valid", instr_valid, 1'b0);
        chk("rst_fetch_align", align_err, 1'b0);

        // Release with the late ack still high: lands in IDLE, ignored
        reset = 1'b0;
        step();
        imem_ack = 1'b0;
        chk("late_ack_instr", Instr, 32'h0);
        chk("late_ack_req", imem_req, 1'b1);
        chk("late_ack_valid", instr_valid, 1'b0);

        // Retire while fetching is ignored
        retire = 1'b1;
        step();
        retire = 1'b0;
        chk("retire_in_fetch_req", imem_req, 1'b1);
        chk("retire_in_fetch_addr", imem_addr, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
